// File: rtl/nn_argmax_reader.sv
// Argmax reader for a 10-class score vector: 10-cycle sequential scan, one-cycle result pulse.
// Optional accuracy tracking (match, correct/total counters) is enabled by defining NN_ARGMAX_ACC_EN.
module nn_argmax_reader (
    input  logic        clk,
    input  logic        rst,
    input  logic        scores_valid,
    input  logic [79:0] scores,
    input  logic [3:0]  label,
    input  logic        clr_cnt,
    output logic        busy,
    output logic [3:0]  class_out,
    output logic [7:0]  max_out,
    output logic        pred_valid,
    output logic        match,
    output logic [9:0]  correct_cnt,
    output logic [9:0]  total_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'd9;
    localparam logic [9:0] CNT_MAX  = 10'd1023;

    state_t      state_r;
    state_t      state_nx_s;
    logic [79:0] cap_scores_r;
    logic [3:0]  idx_r;
    logic [7:0]  run_max_r;
    logic [3:0]  run_pred_r;
    logic [7:0]  cur_score_s;
    logic [7:0]  win_max_s;
    logic [3:0]  win_pred_s;
    logic        busy_r;
    logic        pred_valid_r;
    logic [3:0]  class_r;
    logic [7:0]  max_r;

    function automatic logic [7:0] score_sel(input logic [79:0] vec, input logic [3:0] sel);
        case (sel)
            4'd0:    score_sel = vec[7:0];
            4'd1:    score_sel = vec[15:8];
            4'd2:    score_sel = vec[23:16];
            4'd3:    score_sel = vec[31:24];
            4'd4:    score_sel = vec[39:32];
            4'd5:    score_sel = vec[47:40];
            4'd6:    score_sel = vec[55:48];
            4'd7:    score_sel = vec[63:56];
            4'd8:    score_sel = vec[71:64];
            4'd9:    score_sel = vec[79:72];
            default: score_sel = 8'h00;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; requests arriving outside IDLE are dropped
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (scores_valid) begin
                    state_nx_s = SCAN;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            SCAN: begin
                if (idx_r == LAST_IDX) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = SCAN;
                end
            end
            DONE:    state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Running comparison; strict greater-than keeps the lowest index on ties
    always_comb begin
        cur_score_s = score_sel(cap_scores_r, idx_r);
        win_max_s   = run_max_r;
        win_pred_s  = run_pred_r;
        if (cur_score_s > run_max_r) begin
            win_max_s  = cur_score_s;
            win_pred_s = idx_r;
        end else begin
            win_max_s  = run_max_r;
            win_pred_s = run_pred_r;
        end
    end

    // Capture, scan datapath and registered result outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_scores_r <= 80'd0;
            idx_r        <= 4'd0;
            run_max_r    <= 8'd0;
            run_pred_r   <= 4'd0;
            class_r      <= 4'd0;
            max_r        <= 8'd0;
            busy_r       <= 1'b0;
            pred_valid_r <= 1'b0;
        end else begin
            busy_r       <= (state_nx_s != IDLE);
            pred_valid_r <= (state_nx_s == DONE);
            case (state_r)
                IDLE: begin
                    if (scores_valid) begin
                        cap_scores_r <= scores;
                        idx_r        <= 4'd0;
                        run_max_r    <= 8'd0;
                        run_pred_r   <= 4'd0;
                    end else begin
                        cap_scores_r <= cap_scores_r;
                    end
                end
                SCAN: begin
                    idx_r      <= idx_r + 4'd1;
                    run_max_r  <= win_max_s;
                    run_pred_r <= win_pred_s;
                    if (idx_r == LAST_IDX) begin
                        class_r <= win_pred_s;
                        max_r   <= win_max_s;
                    end else begin
                        class_r <= class_r;
                    end
                end
                DONE:    idx_r <= idx_r;
                default: idx_r <= 4'd0;
            endcase
        end
    end

    assign busy       = busy_r;
    assign pred_valid = pred_valid_r;
    assign class_out  = class_r;
    assign max_out    = max_r;

`ifdef NN_ARGMAX_ACC_EN
    logic [3:0] cap_label_r;
    logic       match_r;
    logic [9:0] correct_r;
    logic [9:0] total_r;

    // Label capture and match flag, updated together with the result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_label_r <= 4'd0;
            match_r     <= 1'b0;
        end else begin
            if ((state_r == IDLE) && scores_valid) begin
                cap_label_r <= label;
            end else begin
                cap_label_r <= cap_label_r;
            end
            if ((state_r == SCAN) && (idx_r == LAST_IDX)) begin
                match_r <= (win_pred_s == cap_label_r);
            end else begin
                match_r <= match_r;
            end
        end
    end

    // Saturating accuracy counters; the clear beats a same-cycle DONE update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            correct_r <= 10'd0;
            total_r   <= 10'd0;
        end else if (clr_cnt) begin
            correct_r <= 10'd0;
            total_r   <= 10'd0;
        end else if (state_r == DONE) begin
            if (total_r != CNT_MAX) begin
                total_r <= total_r + 10'd1;
            end else begin
                total_r <= total_r;
            end
            if (match_r && (correct_r != CNT_MAX)) begin
                correct_r <= correct_r + 10'd1;
            end else begin
                correct_r <= correct_r;
            end
        end else begin
            correct_r <= correct_r;
            total_r   <= total_r;
        end
    end

    assign match       = match_r;
    assign correct_cnt = correct_r;
    assign total_cnt   = total_r;
`else
    logic unused_s;

    assign unused_s    = ^{label, clr_cnt};
    assign match       = 1'b0;
    assign correct_cnt = 10'd0;
    assign total_cnt   = 10'd0;
`endif

endmodule

// File: tb/tb_nn_argmax_reader.sv
// Self-checking bench for nn_argmax_reader: transaction-level model plus directed vectors.
module tb_nn_argmax_reader;

`ifdef NN_ARGMAX_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    localparam logic [79:0] V1 = 80'h000000000000107F2005;
    localparam logic [79:0] V2 = 80'h00004000000040000000;
    localparam logic [79:0] V3 = 80'h00000000000000000000;
    localparam logic [79:0] V4 = 80'hFF000000000000000000;
    localparam logic [79:0] V5 = 80'h01010101010180909010;
    localparam logic [79:0] V6 = 80'h00000000003300000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        scores_valid;
    logic [79:0] scores;
    logic [3:0]  label;
    logic        clr_cnt;
    logic        busy;
    logic [3:0]  class_out;
    logic [7:0]  max_out;
    logic        pred_valid;
    logic        match;
    logic [9:0]  correct_cnt;
    logic [9:0]  total_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // model state
    int       m_cnt = 0;
    bit       m_busy = 1'b0;
    bit       m_pv = 1'b0;
    bit       m_match = 1'b0;
    int       m_class = 0;
    int       m_max = 0;
    int       m_corr = 0;
    int       m_tot = 0;
    int       p_class = 0;
    int       p_max = 0;
    bit       p_match = 1'b0;

    nn_argmax_reader dut (
        .clk(clk), .rst(rst), .scores_valid(scores_valid), .scores(scores),
        .label(label), .clr_cnt(clr_cnt), .busy(busy), .class_out(class_out),
        .max_out(max_out), .pred_valid(pred_valid), .match(match),
        .correct_cnt(correct_cnt), .total_cnt(total_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int acc(input int n);
        return ACC ? n : 0;
    endfunction

    task automatic argmax(input logic [79:0] v, output int cls, output int mx);
        cls = 0;
        mx  = 0;
        for (int j = 0; j < 10; j++) begin
            if (int'(v[8*j +: 8]) > mx) begin
                mx  = int'(v[8*j +: 8]);
                cls = j;
            end
        end
    endtask

    // Transaction model: accept in idle, result 11 cycles later, one DONE cycle
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt = 0; m_busy = 0; m_pv = 0; m_match = 0;
            m_class = 0; m_max = 0; m_corr = 0; m_tot = 0;
        end else begin
            if (ACC && clr_cnt) begin
                m_corr = 0;
                m_tot  = 0;
            end else if (ACC && m_pv) begin
                if (m_tot < 1023) m_tot++;
                if (m_match && m_corr < 1023) m_corr++;
            end
            if (m_cnt == 0) begin
                if (scores_valid) begin
                    argmax(scores, p_class, p_max);
                    p_match = ACC && (p_class == int'(label));
                    m_cnt = 1;
                end
            end else if (m_cnt == 11) begin
                m_cnt = 0;
            end else begin
                m_cnt++;
                if (m_cnt == 11) begin
                    m_class = p_class;
                    m_max   = p_max;
                    m_match = p_match;
                end
            end
            m_busy = (m_cnt != 0);
            m_pv   = (m_cnt == 11);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", busy, m_busy);
            check("cyc_pred_valid", pred_valid, m_pv);
            check("cyc_class_out", class_out, m_class);
            check("cyc_max_out", max_out, m_max);
            check("cyc_match", match, m_match);
            check("cyc_correct_cnt", correct_cnt, m_corr);
            check("cyc_total_cnt", total_cnt, m_tot);
        end
    end

    task automatic send(input logic [79:0] v, input logic [3:0] l);
        scores_valid = 1'b1;
        scores = v;
        label = l;
        @(negedge clk);
        scores_valid = 1'b0;
        scores = ~v;
        label = ~l;
    endtask

    task automatic wait_pred(output int lat);
        lat = 1;
        while (!pred_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!pred_valid) check("pred_valid_timeout", 0, 1);
    endtask

    task automatic check_result(input string tag, input int cls, input int mx, input bit mt,
                                input int corr, input int tot);
        int lat;
        wait_pred(lat);
        check({tag, "_latency"}, lat, 11);
        check({tag, "_class"}, class_out, cls);
        check({tag, "_max"}, max_out, mx);
        check({tag, "_match"}, match, ACC ? mt : 1'b0);
        @(negedge clk);
        check({tag, "_correct"}, correct_cnt, acc(corr));
        check({tag, "_total"}, total_cnt, acc(tot));
    endtask

    initial begin
        int pulses;
        rst = 1'b0; scores_valid = 1'b0; scores = 80'd0; label = 4'd0; clr_cnt = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_class", class_out, 0);
        check("rst_total", total_cnt, 0);

        // accepted on the very first cycle out of reset
        rst = 1'b1;
        send(V1, 4'd2);
        check_result("t1", 2, 8'h7F, 1'b1, 1, 1);
        send(V2, 4'd7);
        check_result("tie", 3, 8'h40, 1'b0, 1, 2);
        send(V3, 4'd0);
        check_result("zero", 0, 8'h00, 1'b1, 2, 3);
        send(V4, 4'd9);
        check_result("ff9", 9, 8'hFF, 1'b1, 3, 4);

        // second request three cycles in is dropped
        send(V5, 4'd1);
        @(negedge clk);
        @(negedge clk);
        scores_valid = 1'b1; scores = V4; label = 4'd9;
        @(negedge clk);
        scores_valid = 1'b0;
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            if (pred_valid) pulses++;
            @(negedge clk);
        end
        check("busy_drop_pulses", pulses, 1);
        check("busy_drop_class", class_out, 1);
        check("busy_drop_max", max_out, 8'h90);
        check("busy_drop_total", total_cnt, acc(5));
        send(V2, 4'd3);
        check_result("after_drop", 3, 8'h40, 1'b1, 5, 6);

        // reset in the middle of a scan
        send(V1, 4'd2);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_class", class_out, 0);
        check("midrst_total", total_cnt, 0);
        pulses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (pred_valid) pulses++;
            @(negedge clk);
        end
        check("midrst_pulses", pulses, 0);
        check("midrst_max", max_out, 0);

        // clear during DONE wins over the count update
        send(V6, 4'd0);
        begin
            int lat;
            wait_pred(lat);
            check("clr_class", class_out, 4);
            check("clr_max", max_out, 8'h33);
        end
        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        check("clr_correct", correct_cnt, 0);
        check("clr_total", total_cnt, 0);

        // back-to-back correct results up to saturation
        scores_valid = 1'b1; scores = V1; label = 4'd2;
        pulses = 0;
        for (int c = 0; c < 1030 * 12 + 100 && pulses < 1030; c++) begin
            @(negedge clk);
            if (pred_valid) pulses++;
        end
        scores_valid = 1'b0;
        check("sat_pulses", pulses, 1030);
        @(negedge clk);
        check("sat_correct", correct_cnt, acc(1023));
        check("sat_total", total_cnt, acc(1023));
        repeat (3) @(negedge clk);
        check("sat_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
